// File: rtl/axi_sram_slave.sv
// AXI4 memory slave backed by a register-array RAM of DEPTH 64-bit words.
// Narrow transfers arrive lane-0 justified and are aligned to the byte
// address internally. Write and read channels run independent FSMs, and
// each FSM has at most one burst outstanding.
module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic [7:0]  s_axi_awlen,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic        s_axi_wlast,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic [7:0]  s_axi_arlen,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        s_axi_rlast,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp
);
    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [63:0] mem [DEPTH];

    // ---------------------------------------------------------------- write
    w_state_t    w_state, w_next;
    logic [31:0] aw_addr_q;
    logic [2:0]  aw_size_q;
    logic [7:0]  aw_len_q;
    logic        aw_bad_q;
    logic [8:0]  w_beat_q;
    logic        w_cnt_err_q;
    logic        w_dec_q;
    logic [1:0]  bresp_q;

    logic             aw_fire, w_fire;
    logic [31:0]      w_addr;
    logic [32:0]      w_diff;
    logic [2:0]       w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_oor;
    logic [63:0]      w_data_sh;
    logic [7:0]       w_strb_sh;
    logic             w_count_bad;
    logic [1:0]       bresp_d;

    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;

    // Beat address, then its offset from BASE_ADDR: bit 32 is the borrow
    // (address below base); any bit above the index field means index >= DEPTH.
    assign w_addr    = aw_addr_q + (32'(w_beat_q) << aw_size_q);
    assign w_diff    = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_off     = w_diff[2:0];
    assign w_idx     = w_diff[IDX_W+2:3];
    assign w_oor     = w_diff[32] | (|w_diff[31:IDX_W+3]);
    assign w_data_sh = s_axi_wdata << {w_off, 3'b000};
    assign w_strb_sh = s_axi_wstrb << w_off;

    // Response for the beat carrying wlast: burst/size/count errors win over range.
    assign w_count_bad = w_cnt_err_q | (w_beat_q != {1'b0, aw_len_q});
    assign bresp_d     = (aw_bad_q | w_count_bad) ? RESP_SLVERR :
                         (w_dec_q | w_oor)        ? RESP_DECERR : RESP_OKAY;

    // Write FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state and channel handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst context: latched AW fields, beat counter and sticky error flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            aw_addr_q   <= '0;
            aw_size_q   <= '0;
            aw_len_q    <= '0;
            aw_bad_q    <= 1'b0;
            w_beat_q    <= '0;
            w_cnt_err_q <= 1'b0;
            w_dec_q     <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else if (aw_fire) begin
            aw_addr_q   <= s_axi_awaddr;
            aw_size_q   <= s_axi_awsize;
            aw_len_q    <= s_axi_awlen;
            aw_bad_q    <= (s_axi_awburst != BURST_INCR) || (s_axi_awsize > 3'd3);
            w_beat_q    <= '0;
            w_cnt_err_q <= 1'b0;
            w_dec_q     <= 1'b0;
        end else if (w_fire) begin
            if (w_beat_q != '1) w_beat_q <= w_beat_q + 9'd1;
            if (w_oor)          w_dec_q  <= 1'b1;
            if (!s_axi_wlast && (w_beat_q >= {1'b0, aw_len_q})) w_cnt_err_q <= 1'b1;
            if (s_axi_wlast)    bresp_q  <= bresp_d;
        end
    end

    assign s_axi_bresp = bresp_q;

    // Byte-lane writes into the RAM for in-range beats of a well-formed burst.
    always_ff @(posedge i_clk) begin
        // NOTE: the RAM array has no reset; contents are undefined until written.
        if (w_fire && !aw_bad_q && !w_oor) begin
            for (int b = 0; b < 8; b++) begin
                if (w_strb_sh[b]) mem[w_idx][b*8 +: 8] <= w_data_sh[b*8 +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_t    r_state, r_next;
    logic [31:0] ar_addr_q;
    logic [2:0]  ar_size_q;
    logic [7:0]  ar_len_q;
    logic        ar_bad_q;
    logic [7:0]  r_beat_q;

    logic             ar_fire, r_fire;
    logic [31:0]      r_addr;
    logic [32:0]      r_diff;
    logic [2:0]       r_off;
    logic [IDX_W-1:0] r_idx;
    logic             r_oor;
    logic [63:0]      r_word;

    assign ar_fire = s_axi_arvalid & s_axi_arready;
    assign r_fire  = s_axi_rvalid & s_axi_rready;
    assign r_addr  = ar_addr_q + (32'(r_beat_q) << ar_size_q);
    assign r_diff  = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign r_off   = r_diff[2:0];
    assign r_idx   = r_diff[IDX_W+2:3];
    assign r_oor   = r_diff[32] | (|r_diff[31:IDX_W+3]);
    assign r_word  = mem[r_idx];

    // Read FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state and R channel outputs; data is read combinationally.
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_rdata   = '0;
        s_axi_rresp   = RESP_OKAY;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = (r_beat_q == ar_len_q);
                if (ar_bad_q)   s_axi_rresp = RESP_SLVERR;
                else if (r_oor) s_axi_rresp = RESP_DECERR;
                else            s_axi_rdata = r_word >> {r_off, 3'b000};
                if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read burst context: latched AR fields and beat counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ar_addr_q <= '0;
            ar_size_q <= '0;
            ar_len_q  <= '0;
            ar_bad_q  <= 1'b0;
            r_beat_q  <= '0;
        end else if (ar_fire) begin
            ar_addr_q <= s_axi_araddr;
            ar_size_q <= s_axi_arsize;
            ar_len_q  <= s_axi_arlen;
            ar_bad_q  <= (s_axi_arburst != BURST_INCR) || (s_axi_arsize > 3'd3);
            r_beat_q  <= '0;
        end else if (r_fire) begin
            r_beat_q  <= r_beat_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized scoreboard bench for axi_sram_slave. A byte-array reference
// model predicts every B and R response when a transaction is issued; a
// negedge monitor pops and compares whenever a response handshake is seen.
module tb_axi_sram_slave;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;
    localparam int          TO    = 200;

    logic        clk, rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [7:0]  awlen, arlen, wstrb;
    logic [63:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;

    axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlen(awlen),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wlast(wlast),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlen(arlen),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rlast(rlast),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------- reference model
    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    logic [7:0]  model_mem [DEPTH*8];
    logic [1:0]  exp_b [$];
    rbeat_t      exp_r [$];
    logic [63:0] wdq [$];
    logic [7:0]  wsq [$];

    function automatic bit model_oor(input logic [31:0] a);
        if (a < BASE) return 1'b1;
        return (a - BASE) >= 32'(DEPTH * 8);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i, input logic [2:0] size);
        logic [31:0] step;
        step = 32'd1 << size;
        return start + 32'(i) * step;
    endfunction

    // Applies the write burst held in wdq/wsq to the model and queues its bresp.
    task automatic model_write(input logic [31:0] addr, input logic [2:0] size,
                               input logic [1:0] burst, input logic [7:0] len, input int nbeats);
        bit shape_bad, any_oor;
        shape_bad = (burst != 2'b01) || (size > 3);
        any_oor   = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            logic [31:0] a;
            a = beat_addr(addr, i, size);
            if (model_oor(a)) any_oor = 1'b1;
            else if (!shape_bad) begin
                int base_byte;
                base_byte = int'((a - BASE) / 8) * 8;
                for (int b = 0; b < 8; b++) begin
                    int lane;
                    lane = int'(a % 8) + b;
                    if (lane < 8 && wsq[i][b]) model_mem[base_byte + lane] = wdq[i][b*8 +: 8];
                end
            end
        end
        if (shape_bad || nbeats != int'(len) + 1) exp_b.push_back(2'b10);
        else if (any_oor)                         exp_b.push_back(2'b11);
        else                                      exp_b.push_back(2'b00);
    endtask

    task automatic model_read(input logic [31:0] addr, input logic [2:0] size,
                              input logic [1:0] burst, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            rbeat_t      e;
            logic [31:0] a;
            a      = beat_addr(addr, i, size);
            e.data = '0;
            e.last = (i == int'(len));
            if (burst != 2'b01 || size > 3) e.resp = 2'b10;
            else if (model_oor(a))          e.resp = 2'b11;
            else begin
                int base_byte;
                e.resp    = 2'b00;
                base_byte = int'((a - BASE) / 8) * 8;
                for (int lane = int'(a % 8); lane < 8; lane++)
                    e.data[(lane - int'(a % 8))*8 +: 8] = model_mem[base_byte + lane];
            end
            exp_r.push_back(e);
        end
    endtask

    // ---------------------------------------------------------------- driver
    task automatic wait_hs(input int ch, input string name);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < TO) begin
            @(negedge clk);
            case (ch)
                0:       hs = awready;
                1:       hs = wready;
                2:       hs = arready;
                default: hs = bvalid;
            endcase
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            tests++;
            fails++;
            $display("FAIL timeout %s: no handshake within %0d cycles", name, TO);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] len, input int nbeats);
        model_write(addr, size, burst, len, nbeats);
        awvalid = 1'b1; awaddr = addr; awsize = size; awburst = burst; awlen = len;
        wait_hs(0, "aw");
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = wdq[i]; wstrb = wsq[i]; wlast = (i == nbeats - 1);
            wait_hs(1, "w");
        end
        wvalid = 1'b0; wlast = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bready = 1'b1;
        wait_hs(3, "b");
        bready = 1'b0;
    endtask

    task automatic issue_ar(input logic [31:0] addr, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] len);
        model_read(addr, size, burst, len);
        arvalid = 1'b1; araddr = addr; arsize = size; arburst = burst; arlen = len;
        wait_hs(2, "ar");
        arvalid = 1'b0;
    endtask

    // Drains one read burst; stall_beat holds rready low for two cycles on that beat.
    task automatic consume_r(input int nbeats, input int stall_beat, input bit throttle);
        int beat, n, stalls;
        bit hs;
        beat = 0; n = 0; stalls = 0;
        while (beat < nbeats && n < TO) begin
            if (beat == stall_beat && stalls < 2) begin
                rready = 1'b0;
                stalls++;
            end else if (throttle) rready = ($urandom_range(0, 2) != 0);
            else                   rready = 1'b1;
            @(negedge clk);
            hs = rvalid && rready;
            @(posedge clk);
            #1;
            if (hs) beat++;
            n++;
        end
        rready = 1'b0;
        if (beat < nbeats) begin
            tests++;
            fails++;
            $display("FAIL timeout r: %0d of %0d beats in %0d cycles", beat, nbeats, TO);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst,
                           input logic [7:0] len, input int stall_beat, input bit throttle);
        issue_ar(addr, size, burst, len);
        consume_r(int'(len) + 1, stall_beat, throttle);
    endtask

    // --------------------------------------------------------------- monitor
    bit     stall_prev = 1'b0;
    rbeat_t held;

    always @(negedge clk) begin
        if (rst) stall_prev = 1'b0;
        else begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bresp_unexpected: got %h expected none", bresp);
                end else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
            end
            if (rvalid && stall_prev) begin
                check("r_hold_data", rdata, held.data);
                check("r_hold_resp", 64'(rresp), 64'(held.resp));
                check("r_hold_last", 64'(rlast), 64'(held.last));
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_unexpected: got %h expected none", rdata);
                end else begin
                    rbeat_t e;
                    e = exp_r.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", 64'(rresp), 64'(e.resp));
                    check("rlast", 64'(rlast), 64'(e.last));
                end
            end
            stall_prev = rvalid && !rready;
            held.data  = rdata;
            held.resp  = rresp;
            held.last  = rlast;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awsize = 0; awburst = 0; awlen = 0;
        wvalid = 0; wlast = 0; wdata = 0; wstrb = 0; bready = 0;
        arvalid = 0; araddr = 0; arsize = 0; arburst = 0; arlen = 0; rready = 0;
        #23;
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_rlast",   64'(rlast),   64'd0);
        check("rst_rdata",   rdata,        64'd0);
        check("rst_rresp",   64'(rresp),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Give every word a known value so reads never see uninitialised RAM.
        for (int w = 0; w < DEPTH; w++) begin
            wdq = {{$urandom, $urandom}}; wsq = {8'hFF};
            do_write(BASE + 32'(w * 8), 3'd3, 2'b01, 8'd0, 1);
        end

        // Dword write and readback.
        wdq = {64'h1122334455667788}; wsq = {8'hFF};
        do_write(BASE + 32'h8, 3'd3, 2'b01, 8'd0, 1);
        do_read(BASE + 32'h8, 3'd3, 2'b01, 8'd0, -1, 1'b0);

        // Lane-0 justified byte write lands in byte lane 5.
        wdq = {64'h0000_0000_0000_00AB}; wsq = {8'h01};
        do_write(BASE + 32'hD, 3'd0, 2'b01, 8'd0, 1);
        do_read(BASE + 32'h8, 3'd3, 2'b01, 8'd0, -1, 1'b0);
        do_read(BASE + 32'hD, 3'd0, 2'b01, 8'd0, -1, 1'b0);

        // Out of range on both sides of the window.
        wdq = {64'hDEAD_BEEF_0000_0001}; wsq = {8'hFF};
        do_write(BASE + 32'h800, 3'd3, 2'b01, 8'd0, 1);
        do_read(BASE - 32'h8, 3'd3, 2'b01, 8'd0, -1, 1'b0);
        do_read(BASE + 32'h7F8, 3'd3, 2'b01, 8'd1, -1, 1'b0);

        // Four-beat INCR burst, read back with beat 1 stalled.
        wdq = {64'd1, 64'd2, 64'd3, 64'd4}; wsq = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_write(BASE, 3'd3, 2'b01, 8'd3, 4);
        do_read(BASE, 3'd3, 2'b01, 8'd3, 1, 1'b0);

        // Malformed bursts: FIXED, short wlast, bad read size and burst type.
        wdq = {64'hAAAA, 64'hBBBB}; wsq = {8'hFF, 8'hFF};
        do_write(BASE + 32'h40, 3'd3, 2'b00, 8'd1, 2);
        wdq = {64'hCCCC, 64'hDDDD}; wsq = {8'hFF, 8'hFF};
        do_write(BASE + 32'h80, 3'd3, 2'b01, 8'd3, 2);
        @(negedge clk);
        check("w_idle_after_short", 64'(awready), 64'd1);
        check("no_wready_idle", 64'(wready), 64'd0);
        @(posedge clk); #1;
        do_read(BASE + 32'h40, 3'd3, 2'b01, 8'd3, -1, 1'b0);
        do_read(BASE + 32'h80, 3'd3, 2'b01, 8'd3, -1, 1'b0);
        do_read(BASE + 32'h80, 3'd4, 2'b01, 8'd1, -1, 1'b0);
        do_read(BASE + 32'h80, 3'd3, 2'b10, 8'd1, -1, 1'b0);

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            logic [1:0]  bu;
            logic [7:0]  ln;
            int          nb;
            a  = BASE + ($urandom % 32'(DEPTH * 8 + 128)) - 32'd64;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            bu = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
            ln = 8'($urandom_range(0, 7));
            nb = int'(ln) + 1;
            if ($urandom_range(0, 9) == 0) nb = (ln > 0) ? int'(ln) : 2;
            wdq.delete(); wsq.delete();
            for (int i = 0; i < nb; i++) begin
                wdq.push_back({$urandom, $urandom});
                wsq.push_back(8'($urandom));
            end
            do_write(a, sz, bu, ln, nb);
            do_read(a, 3'($urandom_range(0, 3)), 2'b01, 8'($urandom_range(0, 7)), -1, 1'b1);
        end

        // Asynchronous reset in the middle of a read burst.
        issue_ar(BASE, 3'd3, 2'b01, 8'd7);
        rready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_rvalid", 64'(rvalid), 64'd0);
        check("async_rst_rlast",  64'(rlast),  64'd0);
        check("async_rst_rdata",  rdata,       64'd0);
        rready = 1'b0;
        exp_r.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_arready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        do_read(BASE + 32'h8, 3'd3, 2'b01, 8'd1, -1, 1'b0);

        repeat (4) @(posedge clk);
        check("exp_b_drained", 64'(exp_b.size()), 64'd0);
        check("exp_r_drained", 64'(exp_r.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
